ccsds123_frame_ctrl: RTL and testbench

Image sequencer between the sample source and ccsds123_top. Admits exactly one image (ceil(NX*NY*NZ/PIPELINES) input beats) at a time. Blocks further input until the compressor emits the matching output tlast, then admits the next image. Counts output beats per image and reports image length, progress and stall statistics to the control side.

---
 rtl/ccsds123_ctrl_pkg.sv | 30 +++
 rtl/ccsds123_beat_counter.sv | 53 +++++
 rtl/ccsds123_frame_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_ccsds123_frame_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccsds123_ctrl_pkg.sv
// ccsds123_ctrl_pkg
//   Shared definitions for the CCSDS-123 image sequencer:
//   - ctrl_state_e : sequencer state encoding
//   - SAT_CNT_W    : default width of the length / stall counters
//   - calc_beats() : input beats needed to carry one NX*NY*NZ image
//   - cnt_width()  : register width able to hold 0..n-1 (minimum 1 bit)
package ccsds123_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } ctrl_state_e;

    localparam int unsigned SAT_CNT_W = 32;

    // A partially filled final beat still costs a whole beat.
    function automatic int unsigned calc_beats(input int unsigned nx,
                                               input int unsigned ny,
                                               input int unsigned nz,
                                               input int unsigned pipelines);
        return (nx * ny * nz + pipelines - 1) / pipelines;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ccsds123_beat_counter.sv
// ccsds123_beat_counter
//   Counter with synchronous clear. In bounded mode it counts 0..N-1 and
//   wraps to 0, pulsing wrap_o on the wrapping increment. In free-running
//   mode (FREE_RUN=1) it rolls over at all-ones and wrap_o marks that.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   clr_i  : synchronous clear, has priority over inc_i
//   inc_i  : count enable
//   cnt_o  : current count
//   wrap_o : combinational pulse, inc_i on the terminal count (no clear)
module ccsds123_beat_counter
    import ccsds123_ctrl_pkg::*;
#(
    parameter int unsigned W        = SAT_CNT_W,
    parameter int unsigned N        = 16,
    parameter bit          FREE_RUN = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = FREE_RUN ? {W{1'b1}} : W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         at_last;

    always_comb begin
        at_last = (cnt_q == LAST);
        wrap_o  = inc_i & at_last & ~clr_i;
        cnt_d   = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = at_last ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ccsds123_frame_ctrl.sv
// ccsds123_frame_ctrl
//   Image sequencer in front of ccsds123_top. Admits exactly one image
//   (BEATS input beats) at a time, then gates the input off until the
//   compressor returns the matching output tlast. Reports per-image output
//   length, images completed, upstream stall cycles and early-tlast errors.
// Ports:
//   clk, rst                      : clock / synchronous active-high reset
//   cmd_start, cmd_num_images     : run command (accepted in IDLE only)
//   s_axis_*                      : upstream sample stream (in)
//   c_axis_*                      : gated sample stream to the compressor
//   cm_axis_*                     : compressor output stream (in)
//   m_axis_*                      : downstream output (pass-through of cm_*)
//   busy                          : STREAM or DRAIN
//   done                          : one-cycle pulse after a run completes
//   len_valid, len_beats          : per-image output length report
//   images_done                   : images completed in the current run
//   in_stall_cnt                  : saturating upstream stall cycle count
//   err_early_last                : sticky, tlast seen before input complete
module ccsds123_frame_ctrl
    import ccsds123_ctrl_pkg::*;
#(
    parameter int unsigned PIPELINES = 2,
    parameter int unsigned D         = 16,
    parameter int unsigned NX        = 4,
    parameter int unsigned NY        = 4,
    parameter int unsigned NZ        = 4,
    parameter int unsigned BUS_WIDTH = 64,
    parameter int unsigned LEN_W     = SAT_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_start,
    input  logic [15:0]            cmd_num_images,
    input  logic [PIPELINES*D-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [PIPELINES*D-1:0] c_axis_tdata,
    output logic                   c_axis_tvalid,
    input  logic                   c_axis_tready,
    input  logic [BUS_WIDTH-1:0]   cm_axis_tdata,
    input  logic                   cm_axis_tvalid,
    input  logic                   cm_axis_tlast,
    output logic                   cm_axis_tready,
    output logic [BUS_WIDTH-1:0]   m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic                   busy,
    output logic                   done,
    output logic                   len_valid,
    output logic [LEN_W-1:0]       len_beats,
    output logic [15:0]            images_done,
    output logic [LEN_W-1:0]       in_stall_cnt,
    output logic                   err_early_last
);

    localparam int unsigned BEATS = calc_beats(NX, NY, NZ, PIPELINES);
    localparam int unsigned IN_W  = cnt_width(BEATS);

    ctrl_state_e      state_q, state_d;
    logic [15:0]      num_q, num_d;
    logic [15:0]      images_q, images_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] stall_q, stall_d;
    logic             len_valid_q, len_valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             in_stream, in_drain, counting;
    logic             c_hs, cm_hs;
    logic             start_acc, early_last, drain_last;
    logic             in_wrap;
    logic [IN_W-1:0]  in_cnt;
    logic [LEN_W-1:0] out_cnt;
    logic             out_wrap;

    // ------------------------------------------------------------------
    // Stream gating and pass-through
    // ------------------------------------------------------------------
    assign in_stream = (state_q == ST_STREAM);
    assign in_drain  = (state_q == ST_DRAIN);
    assign counting  = in_stream | in_drain;

    assign c_axis_tdata  = s_axis_tdata;
    assign c_axis_tvalid = s_axis_tvalid & in_stream;
    assign s_axis_tready = c_axis_tready & in_stream;

    assign m_axis_tdata   = cm_axis_tdata;
    assign m_axis_tvalid  = cm_axis_tvalid;
    assign m_axis_tlast   = cm_axis_tlast;
    assign cm_axis_tready = m_axis_tready;

    assign c_hs  = s_axis_tvalid & c_axis_tready & in_stream;
    assign cm_hs = cm_axis_tvalid & m_axis_tready;

    assign start_acc = (state_q == ST_IDLE) & cmd_start;
    // A tlast in STREAM is early even when it coincides with the last input
    // beat; the clear below then also suppresses the input counter's wrap.
    assign early_last = in_stream & cm_hs & cm_axis_tlast;
    assign drain_last = in_drain & cm_hs & cm_axis_tlast;

    // ------------------------------------------------------------------
    // Beat counters
    // ------------------------------------------------------------------
    ccsds123_beat_counter #(
        .W        (IN_W),
        .N        (BEATS),
        .FREE_RUN (1'b0)
    ) u_in_cnt (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (start_acc | early_last),
        .inc_i  (c_hs),
        .cnt_o  (in_cnt),
        .wrap_o (in_wrap)
    );

    ccsds123_beat_counter #(
        .W        (LEN_W),
        .N        (2),
        .FREE_RUN (1'b1)
    ) u_out_cnt (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (start_acc | early_last | drain_last),
        .inc_i  (cm_hs & counting),
        .cnt_o  (out_cnt),
        .wrap_o (out_wrap)
    );

    // Only the input wrap and the output count drive the sequencer.
    logic unused_cnt;
    assign unused_cnt = ^{in_cnt, out_wrap};

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        images_d    = images_q;
        len_d       = len_q;
        stall_d     = stall_q;
        err_d       = err_q;
        len_valid_d = 1'b0;
        // done trails the DONE state by one cycle.
        done_d      = (state_q == ST_DONE);

        if (in_stream && s_axis_tvalid && !c_axis_tready && (stall_q != '1)) begin
            stall_d = stall_q + LEN_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    num_d    = cmd_num_images;
                    images_d = '0;
                    stall_d  = '0;
                    err_d    = 1'b0;
                    state_d  = (cmd_num_images == '0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (early_last) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (in_wrap) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_last) begin
                    len_d       = out_cnt + LEN_W'(1);
                    len_valid_d = 1'b1;
                    images_d    = images_q + 16'd1;
                    state_d     = ((images_q + 16'd1) == num_q) ? ST_DONE : ST_STREAM;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            num_q       <= '0;
            images_q    <= '0;
            len_q       <= '0;
            stall_q     <= '0;
            len_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            images_q    <= images_d;
            len_q       <= len_d;
            stall_q     <= stall_d;
            len_valid_q <= len_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign busy           = counting;
    assign done           = done_q;
    assign len_valid      = len_valid_q;
    assign len_beats      = len_q;
    assign images_done    = images_q;
    assign in_stall_cnt   = stall_q;
    assign err_early_last = err_q;

endmodule

// File: tb/tb_ccsds123_frame_ctrl.sv
module tb_ccsds123_frame_ctrl;

    localparam int unsigned BEATS = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_start;
    logic [15:0] cmd_num_images;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] c_axis_tdata;
    logic        c_axis_tvalid;
    logic        c_axis_tready;
    logic [63:0] cm_axis_tdata;
    logic        cm_axis_tvalid;
    logic        cm_axis_tlast;
    logic        cm_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        busy;
    logic        done;
    logic        len_valid;
    logic [31:0] len_beats;
    logic [15:0] images_done;
    logic [31:0] in_stall_cnt;
    logic        err_early_last;

    always #5 clk = ~clk;

    ccsds123_frame_ctrl #(
        .PIPELINES (2),
        .D         (16),
        .NX        (4),
        .NY        (4),
        .NZ        (4),
        .BUS_WIDTH (64),
        .LEN_W     (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_start      (cmd_start),
        .cmd_num_images (cmd_num_images),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .c_axis_tdata   (c_axis_tdata),
        .c_axis_tvalid  (c_axis_tvalid),
        .c_axis_tready  (c_axis_tready),
        .cm_axis_tdata  (cm_axis_tdata),
        .cm_axis_tvalid (cm_axis_tvalid),
        .cm_axis_tlast  (cm_axis_tlast),
        .cm_axis_tready (cm_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .busy           (busy),
        .done           (done),
        .len_valid      (len_valid),
        .len_beats      (len_beats),
        .images_done    (images_done),
        .in_stall_cnt   (in_stall_cnt),
        .err_early_last (err_early_last)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int cyc_no, in_beats, img_beats, cm_beats, n_len, n_done;
    int len_cyc, done_cyc, sb_err, hs_err, drain_rdy_err, busy_seen, start_cyc;
    logic [31:0] src_data, sb_exp, last_len;
    logic [31:0] len_log [0:7];
    int t2_len [0:2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        in_beats = 0; img_beats = 0; cm_beats = 0; n_len = 0; n_done = 0;
        len_cyc = -100; done_cyc = -100; sb_err = 0; hs_err = 0;
        drain_rdy_err = 0; busy_seen = 0; last_len = '0;
    endtask

    // One clock cycle: observe mid-cycle, then advance to just past the edge.
    task automatic cyc();
        logic s_hs, c_hs;
        @(negedge clk);
        cyc_no++;
        if (len_valid === 1'b1) begin
            if (n_len < 8) len_log[n_len] = len_beats;
            n_len++;
            last_len = len_beats;
            len_cyc  = cyc_no;
        end
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc_no;
        end
        if (busy === 1'b1) busy_seen = 1;
        // Once a whole image is in, upstream must stay blocked until tlast.
        if (img_beats >= BEATS && s_axis_tready === 1'b1) drain_rdy_err++;
        s_hs = s_axis_tvalid & s_axis_tready;
        c_hs = c_axis_tvalid & c_axis_tready;
        if (s_hs !== c_hs) hs_err++;
        if (c_hs === 1'b1) begin
            in_beats++;
            img_beats++;
            if (c_axis_tdata !== sb_exp) sb_err++;
            sb_exp++;
        end
        if ((cm_axis_tvalid & cm_axis_tready) === 1'b1) cm_beats++;
        @(posedge clk);
        #1;
        if (s_hs === 1'b1) src_data++;
        s_axis_tdata  = src_data;
        cm_axis_tdata = {src_data, ~src_data};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic start(input logic [15:0] num);
        cmd_start      = 1'b1;
        cmd_num_images = num;
        cyc();
        start_cyc = cyc_no;
        cmd_start = 1'b0;
    endtask

    task automatic feed(input int target, input bit rnd);
        int g;
        g = 0;
        c_axis_tready = 1'b1;
        while (img_beats < target && g < 3000) begin
            s_axis_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc();
            g++;
        end
        check("feed_bound", (g < 3000), 1);
        s_axis_tvalid = 1'b1;
    endtask

    task automatic emit(input int n, input int gap);
        for (int i = 1; i <= n; i++) begin
            cm_axis_tvalid = 1'b1;
            cm_axis_tlast  = (i == n);
            m_axis_tready  = 1'b0;
            for (int k = 0; k < gap; k++) cyc();
            m_axis_tready = 1'b1;
            cyc();
        end
        cm_axis_tvalid = 1'b0;
        cm_axis_tlast  = 1'b0;
        img_beats      = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_start = 1'b0; cmd_num_images = '0;
        s_axis_tvalid = 1'b0; c_axis_tready = 1'b1; s_axis_tdata = '0;
        cm_axis_tvalid = 1'b0; cm_axis_tlast = 1'b0; cm_axis_tdata = '0;
        m_axis_tready = 1'b1;
        src_data = '0; sb_exp = '0; cyc_no = 0; start_cyc = 0;
        t2_len[0] = 3; t2_len[1] = 1; t2_len[2] = 4;
        clear_stats();
        idle(3);
        s_axis_tvalid = 1'b1;
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_len_valid", len_valid, 0);
        check("rst_len_beats", len_beats, 0);
        check("rst_images_done", images_done, 0);
        check("rst_stall", in_stall_cnt, 0);
        check("rst_err", err_early_last, 0);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_c_tvalid", c_axis_tvalid, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        idle(1);

        // 1: single image, 5 output beats
        clear_stats();
        start(1);
        feed(BEATS, 1'b0);
        idle(4);
        emit(5, 0);
        idle(4);
        check("t1_in_beats", in_beats, 32);
        check("t1_drain_ready", drain_rdy_err, 0);
        check("t1_n_len", n_len, 1);
        check("t1_len_beats", last_len, 5);
        check("t1_n_done", n_done, 1);
        check("t1_done_lag", done_cyc - len_cyc, 1);
        check("t1_images_done", images_done, 1);
        check("t1_cm_beats", cm_beats, 5);
        check("t1_scoreboard", sb_err, 0);
        check("t1_handshake", hs_err, 0);
        check("t1_busy_end", busy, 0);

        // 2: three images, random upstream valid, slow downstream
        clear_stats();
        start(3);
        for (int img = 0; img < 3; img++) begin
            feed(BEATS, 1'b1);
            emit(t2_len[img], 30);
        end
        idle(4);
        check("t2_in_beats", in_beats, 96);
        check("t2_n_len", n_len, 3);
        check("t2_len0", len_log[0], 3);
        check("t2_len1", len_log[1], 1);
        check("t2_len2", len_log[2], 4);
        check("t2_drain_ready", drain_rdy_err, 0);
        check("t2_n_done", n_done, 1);
        check("t2_images_done", images_done, 3);
        check("t2_scoreboard", sb_err, 0);
        check("t2_handshake", hs_err, 0);

        // 3: zero-image run, output path still passes through
        clear_stats();
        cm_axis_tvalid = 1'b1;
        m_axis_tready  = 1'b1;
        start(0);
        idle(4);
        check("t3_n_done", n_done, 1);
        check("t3_done_cycle", done_cyc - start_cyc, 2);
        check("t3_busy_seen", busy_seen, 0);
        check("t3_in_beats", in_beats, 0);
        check("t3_n_len", n_len, 0);
        check("t3_images_done", images_done, 0);
        check("t3_m_tvalid", m_axis_tvalid, 1);
        check("t3_m_tdata", m_axis_tdata, cm_axis_tdata);
        m_axis_tready = 1'b0;
        #1;
        check("t3_cm_tready", cm_axis_tready, 0);
        m_axis_tready  = 1'b1;
        cm_axis_tvalid = 1'b0;
        idle(1);

        // 4: 10 stall cycles mid-image
        clear_stats();
        start(1);
        feed(5, 1'b0);
        c_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        idle(10);
        check("t4_stall_mid", in_stall_cnt, 10);
        check("t4_no_beat_in_stall", img_beats, 5);
        feed(BEATS, 1'b0);
        emit(2, 0);
        idle(3);
        check("t4_in_beats", in_beats, 32);
        check("t4_scoreboard", sb_err, 0);
        check("t4_handshake", hs_err, 0);
        check("t4_stall_end", in_stall_cnt, 10);
        check("t4_len_beats", last_len, 2);
        check("t4_n_done", n_done, 1);

        // 5: early tlast after 20 input beats
        clear_stats();
        start(1);
        feed(20, 1'b0);
        s_axis_tvalid = 1'b0;
        emit(1, 0);
        s_axis_tvalid = 1'b1;
        idle(3);
        check("t5_err", err_early_last, 1);
        check("t5_busy", busy, 0);
        check("t5_s_tready", s_axis_tready, 0);
        check("t5_n_done", n_done, 0);
        check("t5_n_len", n_len, 0);
        check("t5_in_beats", in_beats, 20);
        check("t5_images_done", images_done, 0);
        start(1);
        check("t5_err_cleared", err_early_last, 0);
        check("t5_busy_restart", busy, 1);
        feed(BEATS, 1'b0);
        emit(1, 0);
        idle(3);
        check("t5_in_beats_total", in_beats, 52);
        check("t5_len_beats", last_len, 1);
        check("t5_n_done_restart", n_done, 1);

        // 6: reset in DRAIN of image 2 of 3
        clear_stats();
        start(3);
        feed(BEATS, 1'b0);
        emit(2, 0);
        feed(BEATS, 1'b0);
        cm_axis_tvalid = 1'b1;
        cm_axis_tlast  = 1'b0;
        cyc();
        cm_axis_tvalid = 1'b0;
        check("t6_drain_busy", busy, 1);
        check("t6_drain_s_tready", s_axis_tready, 0);
        check("t6_drain_images", images_done, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_len_valid", len_valid, 0);
        check("t6_len_beats", len_beats, 0);
        check("t6_images_done", images_done, 0);
        check("t6_stall", in_stall_cnt, 0);
        check("t6_err", err_early_last, 0);
        check("t6_s_tready", s_axis_tready, 0);
        check("t6_c_tvalid", c_axis_tvalid, 0);
        clear_stats();
        start(1);
        feed(BEATS, 1'b0);
        emit(3, 0);
        idle(3);
        check("t6_post_in_beats", in_beats, 32);
        check("t6_post_n_len", n_len, 1);
        check("t6_post_len_beats", last_len, 3);
        check("t6_post_n_done", n_done, 1);
        check("t6_post_images", images_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
